// File: rtl/io_input_conditioner.sv
// Synchronizes the slide switches and active-low push key, debounces the key and emits one
// button pulse plus a registered switch snapshot per accepted press. Define IO_AUTOREPEAT_EN for autorepeat.
module io_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 12500000,
    parameter int CNT_WIDTH       = 24,
    parameter int SW_WIDTH        = 18
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                key_n,
    input  logic [SW_WIDTH-1:0] switches_raw,
    input  logic                wait_req,
    output logic                button,
    output logic [SW_WIDTH-1:0] switches,
    output logic                pressed
);

    // Both terminal counts must fit in the shared counter.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1 ||
        longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_WIDTH) ||
        longint'(REPEAT_CYCLES) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_params
        $error("io_input_conditioner: invalid DEBOUNCE_CYCLES/REPEAT_CYCLES/CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
`ifdef IO_AUTOREPEAT_EN
    localparam logic [CNT_WIDTH-1:0] REP_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_HELD,
        S_RELEASE_DB
    } state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_k1;
    logic                  r_k2;
    logic [SW_WIDTH-1:0]   r_sw1;
    logic [SW_WIDTH-1:0]   r_sw2;
    logic                  r_button;
    logic [SW_WIDTH-1:0]   r_switches;
    logic                  r_pressed;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_k1       <= 1'b0;
            r_k2       <= 1'b0;
            r_sw1      <= '0;
            r_sw2      <= '0;
            r_button   <= 1'b0;
            r_switches <= '0;
            r_pressed  <= 1'b0;
        end else begin
            r_k1     <= ~key_n;
            r_k2     <= r_k1;
            r_sw1    <= switches_raw;
            r_sw2    <= r_sw1;
            r_button <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_k2) begin
                        r_state <= S_PRESS_DB;
                        r_cnt   <= '0;
                    end
                end
                S_PRESS_DB: begin
                    // A bounce on the terminal edge wins: no accept.
                    if (!r_k2) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == DB_LAST) begin
                        r_state   <= S_HELD;
                        r_cnt     <= '0;
                        r_pressed <= 1'b1;
                        if (wait_req) begin
                            r_button   <= 1'b1;
                            r_switches <= r_sw2;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HELD: begin
                    if (!r_k2) begin
                        r_state <= S_RELEASE_DB;
                        r_cnt   <= '0;
                    end
`ifdef IO_AUTOREPEAT_EN
                    else if (r_cnt == REP_LAST) begin
                        r_cnt <= '0;
                        if (wait_req) begin
                            r_button   <= 1'b1;
                            r_switches <= r_sw2;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_RELEASE_DB: begin
                    // Release bounce returns to HELD without a new pulse.
                    if (r_k2) begin
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_pressed <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_pressed <= 1'b0;
                end
            endcase
        end
    end

    assign button   = r_button;
    assign switches = r_switches;
    assign pressed  = r_pressed;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner: directed scenarios plus randomized key/switch/wait traffic
// checked against a debounced-level reference model.
module tb_io_input_conditioner;

    localparam int D  = 4;
    localparam int R  = 8;
    localparam int SW = 18;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          key_n = 1'b1;
    logic          wait_req = 1'b0;
    logic [SW-1:0] switches_raw = '0;
    logic          button;
    logic [SW-1:0] switches;
    logic          pressed;

    always #5 clock = ~clock;

    io_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R),
        .CNT_WIDTH       (CW),
        .SW_WIDTH        (SW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_n        (key_n),
        .switches_raw (switches_raw),
        .wait_req     (wait_req),
        .button       (button),
        .switches     (switches),
        .pressed      (pressed)
    );

    int checks = 0;
    int errors = 0;
    int n_pulses = 0;
    int e_idx = 0;

    typedef struct {
        int            e_n;
        logic [SW-1:0] sw;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: a debounced level that flips after D+1 consecutive opposing synchronized samples.
    logic          m_level, m_s1, m_s2, m_prev;
    int            m_run, m_hold;
    logic [SW-1:0] m_sw1, m_sw2;
    bit            exp_pressed = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h (edge %0d)", name, got, expv, e_idx);
        end
    endtask

    task automatic model_reset();
        m_level = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0; m_prev = 1'b0;
        m_run = 0; m_hold = 0;
        m_sw1 = '0; m_sw2 = '0;
        exp_pressed = 1'b0;
    endtask

    task automatic push_pulse();
        exp_t x;
        x.e_n = e_idx;
        x.sw  = m_sw2;
        exp_q.push_back(x);
    endtask

    // Predicts the effect of the upcoming rising edge from the inputs currently applied.
    task automatic model_edge();
        logic sample;
        e_idx++;
        if (reset) begin
            model_reset();
            return;
        end
        sample = m_s2;
        if (sample != m_level) begin
            m_run++;
            m_hold = 0;
            if (m_run == D + 1) begin
                m_level = sample;
                m_run = 0;
                if (m_level && wait_req) push_pulse();
            end
        end else begin
            m_run = 0;
`ifdef IO_AUTOREPEAT_EN
            if (m_level) begin
                if (m_prev) m_hold++;
                if (m_hold == R) begin
                    m_hold = 0;
                    if (wait_req) push_pulse();
                end
            end
`endif
        end
        m_prev = sample;
        m_s2 = m_s1;
        m_s1 = ~key_n;
        m_sw2 = m_sw1;
        m_sw1 = switches_raw;
        exp_pressed = m_level;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            model_edge();
            @(negedge clock);
            #2;
        end
    endtask

    task automatic hold_key(input logic lvl_n, input int n);
        key_n = lvl_n;
        step(n);
    endtask

    task automatic async_reset(input int cycles);
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_button", 32'(button), 32'd0);
        chk("rst_switches", 32'(switches), 32'd0);
        chk("rst_pressed", 32'(pressed), 32'd0);
        step(cycles);
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a pulse is due and flags any unexpected pulse.
    always @(negedge clock) begin
        if (button === 1'b1) n_pulses++;
        if (exp_q.size() > 0 && exp_q[0].e_n == e_idx) begin
            chk("pulse_present", 32'(button), 32'd1);
            if (button === 1'b1) chk("pulse_switches", 32'(switches), 32'(exp_q[0].sw));
            void'(exp_q.pop_front());
        end else begin
            chk("no_pulse", 32'(button), 32'd0);
        end
        chk("pressed", 32'(pressed), 32'(exp_pressed));
    end

    initial begin
        int p0;
        int len;
        model_reset();
        @(negedge clock);
        #2;
        step(3);
        chk("init_button", 32'(button), 32'd0);
        chk("init_switches", 32'(switches), 32'd0);
        chk("init_pressed", 32'(pressed), 32'd0);
        reset = 1'b0;

        // Clean press
        wait_req = 1'b1;
        switches_raw = 18'h2A5A5;
        p0 = n_pulses;
        hold_key(1'b0, 12);
        hold_key(1'b1, 10);
        chk("clean_pulses", 32'(n_pulses - p0), 32'd1);
        chk("clean_snapshot", 32'(switches), 32'h2A5A5);

        // Press bounce then stable low
        switches_raw = 18'h01234;
        p0 = n_pulses;
        repeat (3) begin
            hold_key(1'b0, 2);
            hold_key(1'b1, 1);
        end
        hold_key(1'b0, 12);
        hold_key(1'b1, 10);
        chk("bounce_pulses", 32'(n_pulses - p0), 32'd1);

        // wait_req low discards the press
        switches_raw = 18'h1;
        hold_key(1'b0, 10);
        hold_key(1'b1, 10);
        wait_req = 1'b0;
        switches_raw = 18'h000FF;
        p0 = n_pulses;
        hold_key(1'b0, 10);
        hold_key(1'b1, 10);
        chk("nowait_pulses", 32'(n_pulses - p0), 32'd0);
        chk("nowait_snapshot", 32'(switches), 32'h1);
        wait_req = 1'b1;
        p0 = n_pulses;
        hold_key(1'b0, 10);
        hold_key(1'b1, 10);
        chk("rewait_pulses", 32'(n_pulses - p0), 32'd1);

        // Release bounce
        switches_raw = 18'h3C3C3;
        p0 = n_pulses;
        hold_key(1'b0, 10);
        repeat (2) begin
            hold_key(1'b1, 2);
            hold_key(1'b0, 1);
        end
        hold_key(1'b1, 10);
        chk("relbounce_pulses", 32'(n_pulses - p0), 32'd1);

        // Reset while in PRESS_DB with cnt=2, key held through it
        key_n = 1'b0;
        step(5);
        async_reset(2);
        p0 = n_pulses;
        step(12);
        hold_key(1'b1, 10);
        chk("post_reset_pulses", 32'(n_pulses - p0), 32'd1);

        // Long hold
        p0 = n_pulses;
        hold_key(1'b0, 30);
        hold_key(1'b1, 12);
`ifdef IO_AUTOREPEAT_EN
        chk("hold30_pulses", 32'(n_pulses - p0), 32'd4);
`else
        chk("hold30_pulses", 32'(n_pulses - p0), 32'd1);
`endif

        // Randomized traffic
        for (int seg = 0; seg < 80; seg++) begin
            key_n = 1'($urandom_range(0, 1));
            len = (key_n == 1'b0) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) begin
                wait_req = ($urandom_range(0, 3) != 0);
                switches_raw = SW'($urandom);
                step(1);
            end
            if ($urandom_range(0, 19) == 0) async_reset(1);
        end

        key_n = 1'b1;
        step(20);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
